mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WAIT_CYCLES, default 1: extra memory access cycles, legal range 0..15.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-low reset; sampled on rising clk.
REQ-004 cpu_req  input  1  CPU requests one memory access; held high until cpu_done.
REQ-005 cpu_we  input  1  1 = write, 0 = read; stable while cpu_req high.
REQ-006 cpu_addr  input  16  CPU access address.
REQ-007 cpu_wdata  input  8  CPU write data.
REQ-008 cpu_rdata  output  8  read data returned to CPU; valid in cpu_done cycle, held until next CPU read completes.
REQ-009 cpu_done  output  1  one-cycle completion pulse to CPU.
REQ-010 dma_req, dma_we, dma_addr (16), dma_wdata (8)  input  same meaning for DMA/loader port.
REQ-011 dma_rdata (8), dma_done (1)  output  same meaning for DMA/loader port.
REQ-012 mem_addr  output  16  address to shared memory.
REQ-013 mem_wdata  output  8  write data to shared memory.
REQ-014 mem_rdata  input  8  read data from shared memory.
REQ-015 mem_out  output  1  memory output enable (read strobe).
REQ-016 mem_in  output  1  memory write strobe.
REQ-017 owner  output  1  current/last grant: 0 = CPU, 1 = DMA.
REQ-018 busy  output  1  high in ACCESS and DONE states.

Function
REQ-019 FSM states SHALL be IDLE, ACCESS, DONE.
REQ-020 IDLE: if any req high, SHALL grant one requester, latch its we/addr/wdata, load wait counter with WAIT_CYCLES, go to ACCESS; else stay IDLE.
REQ-021 Only one requester high: that requester SHALL be granted.
REQ-022 Both high: grant SHALL go to the requester not granted last (round-robin via owner).
REQ-023 ACCESS SHALL last exactly WAIT_CYCLES+1 cycles; counter decrements each cycle, exit when counter is 0.
REQ-024 During ACCESS: mem_addr/mem_wdata SHALL equal latched values; mem_out = ~we, mem_in = we; both strobes 0 outside ACCESS.
REQ-025 Read: mem_rdata SHALL be captured on the last ACCESS cycle into the owner's rdata register.
REQ-026 DONE: exactly one cycle; owner's done pulses high, other done stays 0; next state IDLE.
REQ-027 Latency: req seen in IDLE at cycle N -> ACCESS cycles N+1..N+1+WAIT_CYCLES -> done at cycle N+2+WAIT_CYCLES.
REQ-028 Next grant earliest in IDLE cycle after DONE; back-to-back accesses SHALL therefore be spaced WAIT_CYCLES+3 cycles.
REQ-029 Requester inputs SHALL be ignored outside IDLE; changes mid-access do not affect the access in flight.
REQ-030 Req dropped mid-access: access SHALL complete and done still pulse.
REQ-031 Non-owner rdata SHALL be unchanged by any access.
REQ-032 mem_in and mem_out SHALL never be high in the same cycle.
REQ-033 Address/data width: no arithmetic on address; 16-bit pass-through, 0xFFFF legal.

Reset
REQ-034 rst low at rising edge SHALL force: state IDLE, mem_out=0, mem_in=0, cpu_done=0, dma_done=0, busy=0, owner=1 (CPU wins first tie), mem_addr=0, mem_wdata=0, cpu_rdata=0, dma_rdata=0, counter=0.
REQ-035 Reset during ACCESS SHALL abort it: strobes low the following cycle, no done pulse issued.
REQ-036 Requests high while rst low SHALL not be granted; first grant possible in first cycle with rst high.

Verification
REQ-037 WAIT_CYCLES=1, CPU read 0x1234, mem_rdata=0xA5 -> mem_out high 2 cycles, addr 0x1234, cpu_done at N+3, cpu_rdata=0xA5, dma_done 0.
REQ-038 DMA write 0xFFFF data 0x3C -> mem_in high WAIT_CYCLES+1 cycles, mem_addr=0xFFFF, mem_wdata=0x3C, dma_done pulse, mem_out 0 throughout.
REQ-039 Both req high continuously after reset -> grants CPU, DMA, CPU, DMA; owner toggles; each done single-cycle.
REQ-040 CPU req drops after 1 ACCESS cycle -> access completes, cpu_done still pulses at N+2+WAIT_CYCLES.
REQ-041 rst low in second ACCESS cycle of a write -> next cycle mem_in=0, busy=0, no done; pending req granted first cycle after rst high.
REQ-042 WAIT_CYCLES=0 and WAIT_CYCLES=15 builds -> strobe width 1 and 16 cycles respectively, done at N+2 and N+17.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port (CPU / DMA) arbiter in front of a single shared memory.
// Round-robin on ties, fixed-length access of WAIT_CYCLES+1 cycles, then a one-cycle done pulse.
module mem_arbiter #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_done,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [15:0] dma_addr,
  input  logic [7:0]  dma_wdata,
  output logic [7:0]  dma_rdata,
  output logic        dma_done,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        mem_out,
  output logic        mem_in,
  output logic        owner,
  output logic        busy
);

  // Handshake: a requester raises req (with we/addr/wdata stable) and holds it
  // until its done pulses; the request is only sampled in IDLE, so anything the
  // requester does after the grant cannot alter the access in flight.

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        owner_q, owner_d;
  logic        we_q, we_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  cpu_rdata_q, cpu_rdata_d;
  logic [7:0]  dma_rdata_q, dma_rdata_d;

  logic any_req;
  logic grant_dma;
  logic last_access;

  assign any_req     = cpu_req | dma_req;
  // On a tie the port that did not win last time gets the grant.
  assign grant_dma   = (cpu_req & dma_req) ? ~owner_q : dma_req;
  assign last_access = (state_q == S_ACCESS) && (cnt_q == 4'd0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (any_req) state_d = S_ACCESS;
      S_ACCESS: if (cnt_q == 4'd0) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_out  = (state_q == S_ACCESS) & ~we_q;
    mem_in   = (state_q == S_ACCESS) & we_q;
    busy     = (state_q != S_IDLE);
    cpu_done = (state_q == S_DONE) & ~owner_q;
    dma_done = (state_q == S_DONE) & owner_q;
  end

  always_comb begin
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    if (state_q == S_IDLE && any_req) begin
      owner_d = grant_dma;
      we_d    = grant_dma ? dma_we    : cpu_we;
      addr_d  = grant_dma ? dma_addr  : cpu_addr;
      wdata_d = grant_dma ? dma_wdata : cpu_wdata;
      cnt_d   = WAIT_LOAD;
    end else if (state_q == S_ACCESS && cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end
    if (last_access && !we_q) begin
      if (owner_q) dma_rdata_d = mem_rdata;
      else         cpu_rdata_d = mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q       <= 4'd0;
      owner_q     <= 1'b1;
      we_q        <= 1'b0;
      addr_q      <= 16'd0;
      wdata_q     <= 8'd0;
      cpu_rdata_q <= 8'd0;
      dma_rdata_q <= 8'd0;
    end else begin
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end

  assign owner     = owner_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dma_rdata = dma_rdata_q;

endmodule
